input_debouncer: RTL and testbench

//   Conditions one asynchronous, bouncing input (push-button, switch) into a clean

---
 rtl/input_debouncer_if.sv | 34 +++
 rtl/input_debouncer.sv | 142 ++++++++++++++
 tb/tb_input_debouncer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - signal bundle between a raw input source and the debouncer
//
// Purpose: groups the raw input and the conditioned outputs of input_debouncer.
//   din_async  raw asynchronous input (source -> debouncer)
//   dout       debounced level
//   chg        one-cycle strobe when dout takes a new value
//   rise       one-cycle strobe on dout 0->1
//   fall       one-cycle strobe on dout 1->0
// modport master: the side that owns the raw input and consumes the outputs.
// modport slave : the debouncer itself.

interface input_debouncer_if;
   logic din_async;
   logic dout;
   logic chg;
   logic rise;
   logic fall;

   modport master (
      output din_async,
      input  dout,
      input  chg,
      input  rise,
      input  fall
   );

   modport slave (
      input  din_async,
      output dout,
      output chg,
      output rise,
      output fall
   );
endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser plus stability-counting debounce FSM
//
// Purpose: turns one bouncing asynchronous input into a clean registered level
//   and single-cycle edge strobes. A change is accepted only after STABLE_CYCLES
//   consecutive synchronised samples agree on the new value.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous, active-high reset
//   db   input_debouncer_if.slave: din_async in; dout, chg, rise, fall out
// Parameters:
//   STABLE_CYCLES  agreeing samples needed to accept a change (>= 2)
//   CNT_W          stability counter width (must hold STABLE_CYCLES-1)

module input_debouncer #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input logic             clk,
   input logic             rst,
   input_debouncer_if.slave db
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } state_t;

   // The entering sample counts as the first, so acceptance happens on the
   // sample where the counter already shows STABLE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic             s;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             dout_q, dout_n;
   logic             chg_q, chg_n;
   logic             rise_q, rise_n;
   logic             fall_q, fall_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= db.din_async;
         sync2 <= sync1;
      end
   end

   assign s = sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         chg_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         dout_q  <= dout_n;
         chg_q   <= chg_n;
         rise_q  <= rise_n;
         fall_q  <= fall_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      dout_n  = dout_q;
      chg_n   = 1'b0;
      rise_n  = 1'b0;
      fall_n  = 1'b0;

      case (state_q)
         IDLE_LO: begin
            if (s) begin
               state_n = CHK_HI;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n   = '0;
            end
         end
         CHK_HI: begin
            if (!s) begin
               // bounce: fall back without touching the outputs
               state_n = IDLE_LO;
               cnt_n   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_n = IDLE_HI;
               cnt_n   = '0;
               dout_n  = 1'b1;
               chg_n   = 1'b1;
               rise_n  = 1'b1;
            end else begin
               cnt_n   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_n = CHK_LO;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n   = '0;
            end
         end
         CHK_LO: begin
            if (s) begin
               state_n = IDLE_HI;
               cnt_n   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_n = IDLE_LO;
               cnt_n   = '0;
               dout_n  = 1'b0;
               chg_n   = 1'b1;
               fall_n  = 1'b1;
            end else begin
               cnt_n   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE_LO;
            cnt_n   = '0;
         end
      endcase
   end

   assign db.dout = dout_q;
   assign db.chg  = chg_q;
   assign db.rise = rise_q;
   assign db.fall = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer

module tb_input_debouncer;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   pulses0 = 0;
   int   pulses1 = 0;
   logic ds_q;

   typedef struct {
      int cyc;
      bit rise;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0v;
   exp_t e1v;

   input_debouncer_if ifc0 ();
   input_debouncer_if ifc1 ();

   input_debouncer #(.STABLE_CYCLES(4), .CNT_W(16)) dut0 (
      .clk (clk),
      .rst (rst),
      .db  (ifc0.slave)
   );

   input_debouncer #(.STABLE_CYCLES(16), .CNT_W(16)) dut1 (
      .clk (clk),
      .rst (rst),
      .db  (ifc1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // downstream write-enabled register fed by the slow debouncer
   always @(posedge clk) begin
      if (rst)           ds_q <= 1'b0;
      else if (ifc1.chg) ds_q <= ifc1.dout;
   end

   function automatic exp_t mk(input int c, input bit r);
      exp_t e;
      e.cyc  = c;
      e.rise = r;
      return e;
   endfunction

   // scoreboard pop for the STABLE_CYCLES=4 instance
   always @(negedge clk) begin
      if (ifc0.chg || ifc0.rise || ifc0.fall) begin
         pulses0++;
         tests_run++;
         if ((ifc0.chg !== (ifc0.rise | ifc0.fall)) || (ifc0.rise & ifc0.fall)) begin
            tests_failed++;
            $display("FAIL dut0_strobe_consistency: chg=%b rise=%b fall=%b, need chg=rise|fall and not both", ifc0.chg, ifc0.rise, ifc0.fall);
         end
         tests_run++;
         if (q0.size() == 0) begin
            tests_failed++;
            $display("FAIL dut0_unexpected_pulse: pulse at cycle %0d, expected none", cyc);
         end else begin
            e0v = q0.pop_front();
            if (cyc !== e0v.cyc || ifc0.rise !== e0v.rise || ifc0.fall !== !e0v.rise || ifc0.dout !== e0v.rise) begin
               tests_failed++;
               $display("FAIL dut0_pulse: cycle=%0d rise=%b fall=%b dout=%b, expected cycle=%0d rise=%b fall=%b dout=%b",
                        cyc, ifc0.rise, ifc0.fall, ifc0.dout, e0v.cyc, e0v.rise, !e0v.rise, e0v.rise);
            end
         end
      end
   end

   // scoreboard pop for the STABLE_CYCLES=16 instance
   always @(negedge clk) begin
      if (ifc1.chg || ifc1.rise || ifc1.fall) begin
         pulses1++;
         tests_run++;
         if (q1.size() == 0) begin
            tests_failed++;
            $display("FAIL dut1_unexpected_pulse: pulse at cycle %0d, expected none", cyc);
         end else begin
            e1v = q1.pop_front();
            if (cyc !== e1v.cyc || ifc1.rise !== e1v.rise || ifc1.fall !== !e1v.rise ||
                ifc1.chg !== 1'b1 || ifc1.dout !== e1v.rise) begin
               tests_failed++;
               $display("FAIL dut1_pulse: cycle=%0d chg=%b rise=%b fall=%b dout=%b, expected cycle=%0d chg=1 rise=%b fall=%b dout=%b",
                        cyc, ifc1.chg, ifc1.rise, ifc1.fall, ifc1.dout, e1v.cyc, e1v.rise, !e1v.rise, e1v.rise);
            end
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      ifc0.din_async = 1'b0;
      ifc1.din_async = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc0.din_async = 1'b1;
      ifc1.din_async = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({ifc0.dout, ifc0.chg, ifc0.rise, ifc0.fall} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hold: dout/chg/rise/fall=%b, expected 0000", {ifc0.dout, ifc0.chg, ifc0.rise, ifc0.fall});
         end
      end
      rst = 1'b0;
      q0.push_back(mk(cyc + 1 + 5, 1'b1));
      wait_drain(20);
      tests_run++;
      if (q0.size() != 0) begin
         tests_failed++;
         $display("FAIL reset_release_rise: %0d pending pulses, expected 0", q0.size());
         q0.delete();
      end
      repeat (5) @(negedge clk);
      tests_run++;
      if (ifc0.dout !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_dout_hold: dout=%b, expected 1", ifc0.dout);
      end
   endtask

   task automatic test_clean_step();
      apply_reset();
      @(negedge clk);
      ifc0.din_async = 1'b1;
      q0.push_back(mk(cyc + 1 + 5, 1'b1));
      wait_drain(20);
      tests_run++;
      if (q0.size() != 0 || ifc0.chg !== 1'b0 || ifc0.dout !== 1'b1) begin
         tests_failed++;
         $display("FAIL clean_step: pending=%0d chg=%b dout=%b, expected pending=0 chg=0 dout=1", q0.size(), ifc0.chg, ifc0.dout);
         q0.delete();
      end
   endtask

   task automatic test_falling();
      @(negedge clk);
      ifc0.din_async = 1'b0;
      q0.push_back(mk(cyc + 1 + 5, 1'b0));
      wait_drain(20);
      tests_run++;
      if (q0.size() != 0 || ifc0.chg !== 1'b0 || ifc0.dout !== 1'b0) begin
         tests_failed++;
         $display("FAIL falling_step: pending=%0d chg=%b dout=%b, expected pending=0 chg=0 dout=0", q0.size(), ifc0.chg, ifc0.dout);
         q0.delete();
      end
   endtask

   task automatic test_bounce();
      int p;
      apply_reset();
      p = pulses0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ifc0.din_async = (i % 2 == 0);
         @(negedge clk);
      end
      @(negedge clk);
      ifc0.din_async = 1'b1;
      q0.push_back(mk(cyc + 1 + 5, 1'b1));
      wait_drain(20);
      repeat (10) @(negedge clk);
      tests_run++;
      if (q0.size() != 0 || pulses0 - p != 1 || ifc0.dout !== 1'b1) begin
         tests_failed++;
         $display("FAIL bounce: pending=%0d pulses=%0d dout=%b, expected pending=0 pulses=1 dout=1", q0.size(), pulses0 - p, ifc0.dout);
         q0.delete();
      end
   endtask

   task automatic test_short_glitch();
      int p;
      apply_reset();
      p = pulses0;
      @(negedge clk);
      ifc0.din_async = 1'b1;
      repeat (3) @(negedge clk);
      ifc0.din_async = 1'b0;
      repeat (20) @(negedge clk);
      tests_run++;
      if (pulses0 - p != 0 || ifc0.dout !== 1'b0) begin
         tests_failed++;
         $display("FAIL short_glitch: pulses=%0d dout=%b, expected pulses=0 dout=0", pulses0 - p, ifc0.dout);
      end
   endtask

   task automatic test_reset_mid_check();
      int p;
      apply_reset();
      p = pulses0;
      @(negedge clk);
      ifc0.din_async = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (pulses0 - p != 0 || ifc0.dout !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_check_pre: pulses=%0d dout=%b, expected pulses=0 dout=0", pulses0 - p, ifc0.dout);
      end
      q0.push_back(mk(cyc + 1 + 5, 1'b1));
      wait_drain(20);
      tests_run++;
      if (q0.size() != 0 || ifc0.dout !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_check_post: pending=%0d dout=%b, expected pending=0 dout=1", q0.size(), ifc0.dout);
         q0.delete();
      end
   endtask

   task automatic test_back_to_back();
      int  p;
      bit  level;
      apply_reset();
      p = pulses1;
      level = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         level = ~level;
         ifc1.din_async = level;
         q1.push_back(mk(cyc + 1 + 17, level));
         repeat (39) @(negedge clk);
         tests_run++;
         if (ds_q !== level || ifc1.dout !== level) begin
            tests_failed++;
            $display("FAIL downstream_track_%0d: reg=%b dout=%b, expected %b", i, ds_q, ifc1.dout, level);
         end
      end
      tests_run++;
      if (q1.size() != 0 || pulses1 - p != 5) begin
         tests_failed++;
         $display("FAIL back_to_back_count: pending=%0d pulses=%0d, expected pending=0 pulses=5", q1.size(), pulses1 - p);
         q1.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      ifc0.din_async = 1'b0;
      ifc1.din_async = 1'b0;
      test_reset();
      test_clean_step();
      test_falling();
      test_bounce();
      test_short_glitch();
      test_reset_mid_check();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
